nv_ram_rws_param: RTL and testbench
===================================

NV_RAM_RWS_PARAM -- requirements
Module: nv_ram_rws_param

Interface
REQ-001 SHALL have parameter DW, default 64, data width in bits; must be a multiple of 8, range 8..512.
REQ-002 SHALL have parameter AW, default 6, address width; depth DEPTH = 2**AW, range AW 1..12.
REQ-003 SHALL have parameter OUT_REG, default 0; 1 adds one output pipeline register.
REQ-004 SHALL have parameter BYPASS, default 1; 1 enables write-to-read forwarding on same-edge address match.
REQ-005 SHALL have parameter INIT_CLEAR, default 1; 1 zero-fills the array after reset.
REQ-006 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-007 SHALL have port rstn  input  1  reset, asynchronous assert, active-low.
REQ-008 SHALL have port ra  input  AW  read address.
REQ-009 SHALL have port re  input  1  read enable.
REQ-010 SHALL have port dout  output  DW  read data.
REQ-011 SHALL have port dout_vld  output  1  one-cycle pulse marking new dout.
REQ-012 SHALL have port wa  input  AW  write address.
REQ-013 SHALL have port we  input  1  write enable.
REQ-014 SHALL have port wmask  input  DW/8  byte write enables, bit i covers di[8i+7:8i].
REQ-015 SHALL have port di  input  DW  write data.
REQ-016 SHALL have port pwrbus_ram_pd  input  32  power-bus control; no functional effect.
REQ-017 SHALL have port init_done  output  1  high when the array is accepting accesses.

Function
REQ-018 Controller SHALL have two states: CLEAR and READY.
REQ-019 CLEAR, INIT_CLEAR=1: one word per cycle SHALL be written with all zeros, address counter 0..DEPTH-1, exactly DEPTH cycles, then READY.
REQ-020 INIT_CLEAR=0: state SHALL go to READY on the first rising edge after rstn deasserts.
REQ-021 init_done SHALL be 1 only in READY, registered, rising on the edge that enters READY.
REQ-022 In CLEAR, re and we SHALL be ignored; no read pulse, no user write.
REQ-023 Write, READY: on an edge with we=1, each byte i of M[wa] with wmask[i]=1 SHALL take di byte i; other bytes unchanged. we=1 with wmask=0 SHALL leave memory unchanged.
REQ-024 Read, READY: on an edge with re=1, read register SHALL capture M[ra] as it was before that edge's write.
REQ-025 BYPASS=1 with we=1, re=1, wa==ra on the same edge: captured word SHALL be per-byte merged, di byte where wmask set, else old byte.
REQ-026 BYPASS=0 same collision: captured word SHALL be old M[ra].
REQ-027 Latency: OUT_REG=0, dout/dout_vld SHALL update one edge after the re edge; OUT_REG=1, two edges.
REQ-028 dout SHALL hold its last value when no read completes; later writes to that address SHALL NOT alter held dout.
REQ-029 Back-to-back reads SHALL be accepted every cycle with no bubbles; dout_vld high for consecutive cycles.
REQ-030 Read at address DEPTH-1 and counter wrap SHALL not alias; clear counter SHALL stop at DEPTH-1, not wrap.
REQ-031 pwrbus_ram_pd SHALL be ignored; any value yields identical behaviour.

Reset
REQ-032 rstn low SHALL asynchronously force: state CLEAR (INIT_CLEAR=1) or pre-READY, clear counter 0, init_done 0, dout 0, dout_vld 0, all pipeline registers 0.
REQ-033 Array contents SHALL NOT be reset directly; only the clear sequence zeroes them.
REQ-034 Reset asserted mid-CLEAR or mid-read SHALL abort; in-flight read SHALL produce no dout_vld; clear SHALL restart from address 0.

Verification
REQ-035 Defaults, release rstn -> init_done 0 for 64 cycles then 1; read all 64 addresses -> all dout 0x0, dout_vld each cycle after first.
REQ-036 Write wa=5 di=0x1122334455667788 wmask=0xFF, then wmask=0x0F di=0xAAAAAAAAAAAAAAAA; read ra=5 -> dout 0x11223344AAAAAAAA one cycle later.
REQ-037 BYPASS=1, M[9]=0, same edge we=1 wa=9 di=all-F wmask=0xF0 re=1 ra=9 -> dout 0xFFFFFFFF00000000; BYPASS=0 -> dout 0x0.
REQ-038 OUT_REG=1, reads ra=1,2,3 on consecutive cycles -> dout_vld high 3 cycles starting two edges after first re, data in order.
REQ-039 Pull rstn low at clear counter 30 with re=1 and we=1 pending -> outputs 0 immediately; after release, 64 full clear cycles, no dout_vld during CLEAR.
REQ-040 Toggle pwrbus_ram_pd randomly during random traffic vs. scoreboard model -> zero mismatches.

Source files
------------

// File: rtl/nv_ram_rws_param.sv
// Purpose : 1R1W synchronous RAM with byte write mask, optional write-to-read
//           forwarding, optional output register and a zero-fill sequence after reset.
// Latency : dout/dout_vld one edge after the re edge (OUT_REG=0), two edges (OUT_REG=1).
// Backpressure: none; a read and a write are accepted every cycle once init_done is high.
//
// Ports:
//   clk, rstn              clock, asynchronous active-low reset
//   ra, re                 read address / read enable
//   dout, dout_vld         read data / one-cycle pulse marking new dout
//   wa, we, wmask, di      write address / enable / byte enables / data
//   pwrbus_ram_pd          power-bus control, no functional effect
//   init_done              high while the array accepts accesses
module nv_ram_rws_param #(
  parameter int DW         = 64,
  parameter int AW         = 6,
  parameter int OUT_REG    = 0,
  parameter int BYPASS     = 1,
  parameter int INIT_CLEAR = 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [AW-1:0]   ra,
  input  logic            re,
  output logic [DW-1:0]   dout,
  output logic            dout_vld,
  input  logic [AW-1:0]   wa,
  input  logic            we,
  input  logic [DW/8-1:0] wmask,
  input  logic [DW-1:0]   di,
  input  logic [31:0]     pwrbus_ram_pd,
  output logic            init_done
);

  localparam int DEPTH = 1 << AW;
  localparam int NB    = DW / 8;

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            init_done_q, init_done_d;

  logic [DW-1:0]   mem [DEPTH];

  logic            rd_en, wr_en, clr_en;
  logic [DW-1:0]   mem_wa, mem_ra;
  logic [DW-1:0]   wr_word, rd_word;

  logic            s1_vld_q, s1_vld_d;
  logic [DW-1:0]   s1_dat_q, s1_dat_d;

  // The power bus only steers RAM macro power modes; it is folded here so it
  // is visibly consumed without influencing any logic.
  logic            pwrbus_unused;
  assign pwrbus_unused = ^pwrbus_ram_pd;

  // ---------------------------------------------------------------------------
  // Controller: CLEAR walks the counter 0..DEPTH-1 writing zeros, then READY.
  // The counter holds at DEPTH-1 rather than wrapping.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_CLEAR) begin
      if (INIT_CLEAR == 0) begin
        state_d = ST_READY;
      end else if (cnt_q == {AW{1'b1}}) begin
        state_d = ST_READY;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    init_done_d = (state_d == ST_READY);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_CLEAR;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
    end
  end

  assign init_done = init_done_q;

  // User accesses are only honoured in READY.
  assign rd_en  = re && (state_q == ST_READY);
  assign wr_en  = we && (state_q == ST_READY);
  assign clr_en = (INIT_CLEAR != 0) && (state_q == ST_CLEAR);

  assign mem_wa = mem[wa];
  assign mem_ra = mem[ra];

  // Byte-merged write word; with wmask all zero it equals the old word.
  always_comb begin
    wr_word = mem_wa;
    for (int b = 0; b < NB; b++) begin
      if (wmask[b]) begin
        wr_word[8*b +: 8] = di[8*b +: 8];
      end
    end
  end

  // On a same-edge address collision the forwarded word is the merged write
  // word, which already holds old bytes wherever wmask is clear.
  always_comb begin
    rd_word = mem_ra;
    if ((BYPASS != 0) && wr_en && (wa == ra)) begin
      rd_word = wr_word;
    end
  end

  // Array storage is deliberately not reset; only the clear walk zeroes it.
  always_ff @(posedge clk) begin
    if (clr_en) begin
      mem[cnt_q] <= '0;
    end else if (wr_en) begin
      mem[wa] <= wr_word;
    end
  end

  // ---------------------------------------------------------------------------
  // Read pipeline. Data registers only load on a completing read so dout
  // holds its last value otherwise.
  // ---------------------------------------------------------------------------
  always_comb begin
    s1_vld_d = rd_en;
    s1_dat_d = rd_en ? rd_word : s1_dat_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_vld_q <= 1'b0;
      s1_dat_q <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s1_dat_q <= s1_dat_d;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic          s2_vld_q, s2_vld_d;
      logic [DW-1:0] s2_dat_q, s2_dat_d;

      always_comb begin
        s2_vld_d = s1_vld_q;
        s2_dat_d = s1_vld_q ? s1_dat_q : s2_dat_q;
      end

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          s2_vld_q <= 1'b0;
          s2_dat_q <= '0;
        end else begin
          s2_vld_q <= s2_vld_d;
          s2_dat_q <= s2_dat_d;
        end
      end

      assign dout     = s2_dat_q;
      assign dout_vld = s2_vld_q;
    end else begin : g_noreg
      assign dout     = s1_dat_q;
      assign dout_vld = s1_vld_q;
    end
  endgenerate

endmodule

// File: tb/tb_nv_ram_rws_param.sv
// Purpose : directed + randomized check of nv_ram_rws_param in four parameterizations.
// Latency : n/a (testbench).
// Backpressure: n/a (testbench).
module tb_nv_ram_rws_param;

  logic        clk;
  logic        rstn;
  logic [5:0]  ra, wa;
  logic        re, we;
  logic [7:0]  wmask;
  logic [63:0] di;
  logic [31:0] pwr;

  logic [63:0] dout0, dout1, dout2, dout3;
  logic        vld0, vld1, vld2, vld3;
  logic        idone0, idone1, idone2, idone3;

  int n_chk = 0;
  int n_err = 0;

  // u0: defaults, u1: BYPASS=0, u2: OUT_REG=1, u3: INIT_CLEAR=0
  nv_ram_rws_param u0 (.clk(clk), .rstn(rstn), .ra(ra), .re(re), .dout(dout0), .dout_vld(vld0),
    .wa(wa), .we(we), .wmask(wmask), .di(di), .pwrbus_ram_pd(pwr), .init_done(idone0));
  nv_ram_rws_param #(.BYPASS(0)) u1 (.clk(clk), .rstn(rstn), .ra(ra), .re(re), .dout(dout1),
    .dout_vld(vld1), .wa(wa), .we(we), .wmask(wmask), .di(di), .pwrbus_ram_pd(pwr), .init_done(idone1));
  nv_ram_rws_param #(.OUT_REG(1)) u2 (.clk(clk), .rstn(rstn), .ra(ra), .re(re), .dout(dout2),
    .dout_vld(vld2), .wa(wa), .we(we), .wmask(wmask), .di(di), .pwrbus_ram_pd(pwr), .init_done(idone2));
  nv_ram_rws_param #(.INIT_CLEAR(0)) u3 (.clk(clk), .rstn(rstn), .ra(ra), .re(re), .dout(dout3),
    .dout_vld(vld3), .wa(wa), .we(we), .wmask(wmask), .di(di), .pwrbus_ram_pd(pwr), .init_done(idone3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [63:0] mdl [64];
  logic        e0_vld, e2_vld;
  logic [63:0] e0_dout, e1_dout, e2_dout;

  typedef struct {
    logic        w;
    logic [5:0]  wa;
    logic [7:0]  m;
    logic [63:0] d;
    logic        r;
    logic [5:0]  ra;
    logic        ev;
    logic [63:0] ed0;  // expected dout, BYPASS=1
    logic [63:0] ed1;  // expected dout, BYPASS=0
  } vec_t;

  vec_t tv [10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one cycle of traffic, advance the model, clock, then compare all
  // READY-phase instances against the model.
  task automatic do_cycle(input logic w, input logic [5:0] a_w, input logic [7:0] m,
                          input logic [63:0] d, input logic r, input logic [5:0] a_r);
    logic [63:0] old_r, merged;
    we = w; wa = a_w; wmask = m; di = d; re = r; ra = a_r;
    pwr = $urandom;
    if (e0_vld) e2_dout = e0_dout;
    e2_vld = e0_vld;
    old_r  = mdl[a_r];
    merged = old_r;
    if (w && (a_w == a_r)) begin
      for (int b = 0; b < 8; b++) if (m[b]) merged[8*b +: 8] = d[8*b +: 8];
    end
    if (r) begin
      e0_dout = merged;
      e1_dout = old_r;
    end
    e0_vld = r;
    if (w) begin
      for (int b = 0; b < 8; b++) if (m[b]) mdl[a_w][8*b +: 8] = d[8*b +: 8];
    end
    @(posedge clk); #1;
    chk("u0_vld", {63'd0, vld0}, {63'd0, e0_vld});
    chk("u0_dout", dout0, e0_dout);
    chk("u1_vld", {63'd0, vld1}, {63'd0, e0_vld});
    chk("u1_dout", dout1, e1_dout);
    chk("u2_vld", {63'd0, vld2}, {63'd0, e2_vld});
    chk("u2_dout", dout2, e2_dout);
  endtask

  initial begin
    tv[0] = '{1'b1, 6'd5,  8'hFF, 64'h1122334455667788, 1'b0, 6'd0,  1'b0, 64'h0, 64'h0};
    tv[1] = '{1'b1, 6'd5,  8'h0F, 64'hAAAAAAAAAAAAAAAA, 1'b0, 6'd0,  1'b0, 64'h0, 64'h0};
    tv[2] = '{1'b0, 6'd0,  8'h00, 64'h0,                1'b1, 6'd5,  1'b1,
              64'h11223344AAAAAAAA, 64'h11223344AAAAAAAA};
    tv[3] = '{1'b1, 6'd9,  8'hF0, 64'hFFFFFFFFFFFFFFFF, 1'b1, 6'd9,  1'b1,
              64'hFFFFFFFF00000000, 64'h0};
    tv[4] = '{1'b0, 6'd0,  8'h00, 64'h0,                1'b0, 6'd0,  1'b0,
              64'hFFFFFFFF00000000, 64'h0};
    tv[5] = '{1'b1, 6'd9,  8'h00, 64'h0123456789ABCDEF, 1'b1, 6'd9,  1'b1,
              64'hFFFFFFFF00000000, 64'hFFFFFFFF00000000};
    tv[6] = '{1'b1, 6'd0,  8'hFF, 64'h0102030405060708, 1'b1, 6'd63, 1'b1, 64'h0, 64'h0};
    tv[7] = '{1'b0, 6'd0,  8'h00, 64'h0,                1'b1, 6'd0,  1'b1,
              64'h0102030405060708, 64'h0102030405060708};
    tv[8] = '{1'b1, 6'd0,  8'h01, 64'h00000000000000FF, 1'b0, 6'd0,  1'b0,
              64'h0102030405060708, 64'h0102030405060708};
    tv[9] = '{1'b0, 6'd0,  8'h00, 64'h0,                1'b1, 6'd0,  1'b1,
              64'h01020304050607FF, 64'h01020304050607FF};

    rstn = 1'b0; re = 1'b0; we = 1'b0; ra = '0; wa = '0; wmask = '0; di = '0; pwr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_idone0", {63'd0, idone0}, 64'd0);
    chk("rst_vld0",   {63'd0, vld0},   64'd0);
    chk("rst_dout0",  dout0,           64'd0);
    chk("rst_vld2",   {63'd0, vld2},   64'd0);
    chk("rst_idone3", {63'd0, idone3}, 64'd0);

    // Start a clear with traffic pending, then abort it at counter 30.
    rstn = 1'b1;
    re = 1'b1; ra = 6'd7; we = 1'b1; wa = 6'd3; wmask = 8'hFF; di = '1;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      chk("clr1_vld0",   {63'd0, vld0},   64'd0);
      chk("clr1_idone0", {63'd0, idone0}, 64'd0);
    end
    #2 rstn = 1'b0;
    #1;
    chk("abort_idone0", {63'd0, idone0}, 64'd0);
    chk("abort_vld0",   {63'd0, vld0},   64'd0);
    chk("abort_dout0",  dout0,           64'd0);
    chk("abort_vld3",   {63'd0, vld3},   64'd0);
    chk("abort_dout3",  dout3,           64'd0);
    chk("abort_idone3", {63'd0, idone3}, 64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;

    // Full clear: init_done low for 64 edges, rises on the 64th.
    for (int c = 1; c <= 64; c++) begin
      @(posedge clk); #1;
      chk("clr2_idone0", {63'd0, idone0}, (c == 64) ? 64'd1 : 64'd0);
      chk("clr2_vld0",   {63'd0, vld0},   64'd0);
      chk("clr2_vld2",   {63'd0, vld2},   64'd0);
      if (c == 1) chk("noclr_idone3", {63'd0, idone3}, 64'd1);
    end
    re = 1'b0; we = 1'b0;

    for (int i = 0; i < 64; i++) mdl[i] = '0;
    e0_vld = 1'b0; e2_vld = 1'b0; e0_dout = '0; e1_dout = '0; e2_dout = '0;

    // Read back the whole array; the write pending during clear must not land.
    for (int i = 0; i < 64; i++) begin
      do_cycle(1'b0, 6'd0, 8'h00, 64'h0, 1'b1, 6'(i));
      chk("sweep_dout0", dout0, 64'h0);
    end
    do_cycle(1'b0, 6'd0, 8'h00, 64'h0, 1'b0, 6'd0);

    for (int i = 0; i < 10; i++) begin
      do_cycle(tv[i].w, tv[i].wa, tv[i].m, tv[i].d, tv[i].r, tv[i].ra);
      chk("tbl_vld0",  {63'd0, vld0}, {63'd0, tv[i].ev});
      chk("tbl_dout0", dout0, tv[i].ed0);
      chk("tbl_dout1", dout1, tv[i].ed1);
    end

    // OUT_REG=1 back-to-back reads.
    do_cycle(1'b1, 6'd1, 8'hFF, 64'h1111111111111111, 1'b0, 6'd0);
    do_cycle(1'b1, 6'd2, 8'hFF, 64'h2222222222222222, 1'b0, 6'd0);
    do_cycle(1'b1, 6'd3, 8'hFF, 64'h3333333333333333, 1'b0, 6'd0);
    do_cycle(1'b0, 6'd0, 8'h00, 64'h0, 1'b1, 6'd1);
    chk("oreg_vld_a", {63'd0, vld2}, 64'd0);
    do_cycle(1'b0, 6'd0, 8'h00, 64'h0, 1'b1, 6'd2);
    chk("oreg_vld_b", {63'd0, vld2}, 64'd1);
    chk("oreg_dat_b", dout2, 64'h1111111111111111);
    do_cycle(1'b0, 6'd0, 8'h00, 64'h0, 1'b1, 6'd3);
    chk("oreg_vld_c", {63'd0, vld2}, 64'd1);
    chk("oreg_dat_c", dout2, 64'h2222222222222222);
    do_cycle(1'b0, 6'd0, 8'h00, 64'h0, 1'b0, 6'd0);
    chk("oreg_vld_d", {63'd0, vld2}, 64'd1);
    chk("oreg_dat_d", dout2, 64'h3333333333333333);
    do_cycle(1'b0, 6'd0, 8'h00, 64'h0, 1'b0, 6'd0);
    chk("oreg_vld_e", {63'd0, vld2}, 64'd0);
    chk("oreg_dat_e", dout2, 64'h3333333333333333);

    // Random traffic on a small address window to force collisions; the
    // power bus is randomized inside do_cycle.
    for (int i = 0; i < 400; i++) begin
      do_cycle(1'($urandom), 6'($urandom_range(0, 7)), 8'($urandom),
               {$urandom, $urandom}, 1'($urandom), 6'($urandom_range(0, 7)));
    end
    // Touch the top address in the random phase as well.
    do_cycle(1'b1, 6'd63, 8'hA5, 64'hDEADBEEFCAFEF00D, 1'b1, 6'd63);
    do_cycle(1'b0, 6'd0, 8'h00, 64'h0, 1'b1, 6'd63);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
